req_slot_table: RTL
===================

REQ_SLOT_TABLE -- requirements
Module: req_slot_table

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of request slots; SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_WIDTH, default 64: payload width per slot.
REQ-003 Parameter SLOT_W, default $clog2(NUM_SLOTS): slot index width; SHALL NOT be overridden.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 enq_valid  input  1  producer offers a request.
REQ-007 enq_data  input  DATA_WIDTH  request payload.
REQ-008 enq_ready  output  1  at least one slot is FREE.
REQ-009 iss_valid  output  1  registered issue output holds a request.
REQ-010 iss_data  output  DATA_WIDTH  payload of held request.
REQ-011 iss_slot  output  SLOT_W  slot index of held request.
REQ-012 iss_ready  input  1  consumer accepts held request.
REQ-013 cpl_valid  input  1  completion of an issued request.
REQ-014 cpl_slot  input  SLOT_W  slot index being completed.
REQ-015 free_cnt  output  SLOT_W+1  number of FREE slots, registered.
REQ-016 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-017 Each slot SHALL hold a state FREE, WAIT or ISSUED plus DATA_WIDTH payload.
REQ-018 enq_ready SHALL be the OR of FREE flags from registered state; it SHALL NOT depend on enq_valid, iss_ready or cpl_valid.
REQ-019 On enq_valid & enq_ready the lowest-index FREE slot (LSB priority) SHALL capture enq_data and become WAIT.
REQ-020 The output register SHALL load when empty or on iss_valid & iss_ready in the same cycle.
REQ-021 On load, the lowest-index WAIT slot SHALL be captured into iss_data/iss_slot and that slot SHALL become ISSUED; with no WAIT slot, iss_valid SHALL drop (or stay low).
REQ-022 While iss_valid is high and iss_ready is low, iss_valid, iss_data and iss_slot SHALL hold stable.
REQ-023 Enqueue-to-issue latency SHALL be 2 cycles: enq handshake in cycle t with empty output register gives iss_valid high in cycle t+2.
REQ-024 Back-to-back throughput SHALL be one issue per cycle while WAIT slots exist and iss_ready stays high.
REQ-025 On cpl_valid with cpl_slot in ISSUED and not held in the output register, that slot SHALL become FREE next cycle.
REQ-026 A slot freed in cycle t SHALL NOT be allocatable before cycle t+1; simultaneous enq and cpl SHALL both take effect.
REQ-027 When all slots are non-FREE, enq_ready SHALL be 0 and enq_valid SHALL be ignored.
REQ-028 cpl_valid to a FREE or WAIT slot, or to the slot held in the output register, SHALL change no state.
REQ-029 free_cnt SHALL equal the FREE-slot count after each edge and range 0..NUM_SLOTS.

Reset
REQ-030 While rst is high at a clock edge, all slots SHALL become FREE, iss_valid 0, iss_data 0, iss_slot 0, free_cnt NUM_SLOTS and err 0.
REQ-031 enq_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL discard all WAIT, ISSUED and held requests without issuing them.

Configuration
REQ-033 Macro REQ_SLOT_TABLE_ERR_CHECK_EN defined: err SHALL set on any REQ-028 completion and hold until reset.
REQ-034 Macro REQ_SLOT_TABLE_ERR_CHECK_EN undefined: err SHALL be constant 0 and no checking logic SHALL be built; all other behaviour SHALL be identical.

Verification (NUM_SLOTS=8, DATA_WIDTH=16)
REQ-035 Reset, then one enq of 0xA5A5 with iss_ready=1 -> iss_valid high 2 cycles later, iss_slot=0, iss_data=0xA5A5, free_cnt=7.
REQ-036 Enq 8 requests, iss_ready=0 -> enq_ready=0 after the 8th, free_cnt=0, iss_slot=0 held stable; 9th enq_valid ignored.
REQ-037 Slots 0-7 ISSUED, cpl slot 5 then slot 2, then enq 0x1111 and 0x2222 -> they land in slots 2 and 5 respectively.
REQ-038 Table full, cpl slot 3 and enq_valid in same cycle -> no allocation that cycle; allocation to slot 3 next cycle.
REQ-039 With REQ_SLOT_TABLE_ERR_CHECK_EN, cpl to FREE slot 6 -> err=1 sticky, free_cnt unchanged; without macro -> err stays 0.
REQ-040 Reset asserted with 4 WAIT and 1 held request -> next cycle iss_valid=0, free_cnt=8, no stale issue afterwards.

Source files
------------

// File: rtl/req_slot_table_if.sv
// Request slot table bus: enqueue, issue and completion channels plus status.
// The DUT attaches through the slave modport; the producer/consumer side uses master.
interface req_slot_table_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SLOT_W     = 3
) ();
  logic                  enq_valid;
  logic [DATA_WIDTH-1:0] enq_data;
  logic                  enq_ready;
  logic                  iss_valid;
  logic [DATA_WIDTH-1:0] iss_data;
  logic [SLOT_W-1:0]     iss_slot;
  logic                  iss_ready;
  logic                  cpl_valid;
  logic [SLOT_W-1:0]     cpl_slot;
  logic [SLOT_W:0]       free_cnt;
  logic                  err;

  modport slave (
    input  enq_valid, enq_data, iss_ready, cpl_valid, cpl_slot,
    output enq_ready, iss_valid, iss_data, iss_slot, free_cnt, err
  );

  modport master (
    output enq_valid, enq_data, iss_ready, cpl_valid, cpl_slot,
    input  enq_ready, iss_valid, iss_data, iss_slot, free_cnt, err
  );
endinterface

// File: rtl/req_slot_table.sv
// Request slot table: requests are allocated into the lowest FREE slot, issued in
// lowest-index order through a registered output stage, and freed on completion.
// Optional macro REQ_SLOT_TABLE_ERR_CHECK_EN builds a sticky error flag for
// completions that target a FREE, WAIT or currently held slot.
module req_slot_table #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SLOT_W     = $clog2(NUM_SLOTS)
) (
  input logic             clk,
  input logic             rst,
  req_slot_table_if.slave bus
);

  localparam logic [1:0] SlotFree   = 2'd0;
  localparam logic [1:0] SlotWait   = 2'd1;
  localparam logic [1:0] SlotIssued = 2'd2;

  localparam logic [SLOT_W:0] FreeAll = (SLOT_W + 1)'(NUM_SLOTS);

  logic [1:0]            state_q   [NUM_SLOTS];
  logic [1:0]            state_d   [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] payload_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] payload_d [NUM_SLOTS];

  logic                  iss_valid_q, iss_valid_d;
  logic [DATA_WIDTH-1:0] iss_data_q, iss_data_d;
  logic [SLOT_W-1:0]     iss_slot_q, iss_slot_d;
  logic [SLOT_W:0]       free_cnt_q, free_cnt_d;

  logic              any_free, any_wait;
  logic [SLOT_W-1:0] alloc_idx, issue_idx;
  logic              enq_fire, iss_load, cpl_held, cpl_fire;

  // Lowest-index FREE and WAIT slots from registered state
  always_comb begin
    any_free  = 1'b0;
    any_wait  = 1'b0;
    alloc_idx = '0;
    issue_idx = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (state_q[i] == SlotFree) begin
        any_free  = 1'b1;
        alloc_idx = SLOT_W'(i);
      end
      if (state_q[i] == SlotWait) begin
        any_wait  = 1'b1;
        issue_idx = SLOT_W'(i);
      end
    end
  end

  // Handshake qualification; a completion to the held slot is ignored
  always_comb begin
    enq_fire = bus.enq_valid && any_free;
    iss_load = !iss_valid_q || bus.iss_ready;
    cpl_held = iss_valid_q && (iss_slot_q == bus.cpl_slot);
    cpl_fire = bus.cpl_valid && (state_q[bus.cpl_slot] == SlotIssued) && !cpl_held;
  end

  // Next slot state, payload capture, output register and free count
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    iss_valid_d = iss_valid_q;
    iss_data_d  = iss_data_q;
    iss_slot_d  = iss_slot_q;
    free_cnt_d  = '0;
    if (enq_fire) begin
      state_d[alloc_idx]   = SlotWait;
      payload_d[alloc_idx] = bus.enq_data;
    end
    if (iss_load) begin
      iss_valid_d = any_wait;
      if (any_wait) begin
        state_d[issue_idx] = SlotIssued;
        iss_data_d         = payload_q[issue_idx];
        iss_slot_d         = issue_idx;
      end
    end
    if (cpl_fire) begin
      state_d[bus.cpl_slot] = SlotFree;
    end
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (state_d[i] == SlotFree) begin
        free_cnt_d = free_cnt_d + {{SLOT_W{1'b0}}, 1'b1};
      end
    end
  end

  // Slot states, output register and free count with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        state_q[i] <= SlotFree;
      end
      iss_valid_q <= 1'b0;
      iss_data_q  <= '0;
      iss_slot_q  <= '0;
      free_cnt_q  <= FreeAll;
    end else begin
      state_q     <= state_d;
      iss_valid_q <= iss_valid_d;
      iss_data_q  <= iss_data_d;
      iss_slot_q  <= iss_slot_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  // Payload storage needs no reset; only slots marked WAIT are ever read
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

`ifdef REQ_SLOT_TABLE_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky flag for completions that change no state
  always_comb begin
    err_d = err_q || (bus.cpl_valid && !cpl_fire);
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.enq_ready = any_free;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_data  = iss_data_q;
  assign bus.iss_slot  = iss_slot_q;
  assign bus.free_cnt  = free_cnt_q;

endmodule
